conv_encoder: RTL and testbench
===============================

// Module: conv_encoder
// PURPOSE
//  Rate-1/2 feedforward convolutional encoder: transmit-side counterpart of the Viterbi decoder.
//  Accepts a framed bit stream (valid/ready) and emits one 2-bit code symbol per input bit.
//  Optionally appends M zero tail bits per frame, so the decoder traceback can start from state 0.
//  State convention is identical to the decoder's: next_state = {state[M-2:0], in_bit}.
// PARAMETERS
//  M        6         encoder memory (constraint length K = M+1); M >= 2
//  G0       7'o171    generator for out_sym[0]; width M+1; bit 0 taps current input, bit M oldest
//  G1       7'o133    generator for out_sym[1]; same layout as G0
//  TAIL_EN  1         1: append M zero tail symbols after in_last; 0: no tail
// PORTS
//  clk        in   1    clock; all logic on rising edge
//  rst        in   1    synchronous, active-high reset
//  in_valid   in   1    in_bit valid
//  in_ready   out  1    encoder accepts in_bit this cycle
//  in_bit     in   1    information bit
//  in_last    in   1    qualifies in_bit as final bit of frame
//  out_valid  out  1    out_sym valid
//  out_ready  in   1    downstream accepts out_sym this cycle
//  out_sym    out  2    {y1, y0} code symbol
//  out_last   out  1    marks final symbol of frame (last tail symbol, or last data symbol if TAIL_EN=0)
//  busy       out  1    high in TAIL state or while out_valid
// BEHAVIOUR
//  - Reset (rst=1 at clock edge): state=0, FSM=DATA, tail_cnt=0; out_valid=0, out_sym=0,
//    out_last=0, busy=0. Mid-frame reset discards pending symbol and tail; no partial output.
//  - Encode: r = {state, b} (M+1 bits); y0 = ^(r & G0); y1 = ^(r & G1); state <= {state[M-2:0], b}.
//  - Single output register (no deeper buffer). out_free = !out_valid || out_ready.
//  - FSM DATA: in_ready = out_free. Accept (in_valid && in_ready): load out_sym from in_bit,
//    out_valid<=1, advance state. Symbol appears the cycle after acceptance (latency 1).
//    Accepted with in_last: if TAIL_EN, go to TAIL, tail_cnt<=0, out_last<=0;
//    else out_last<=1, state<=0 (each frame starts from state 0).
//    No accept while out_free: out_valid<=0.
//  - FSM TAIL: in_ready=0. Each cycle with out_free: load symbol for b=0, advance state,
//    tail_cnt++. tail_cnt==M-1 load sets out_last=1 and returns to DATA; state is 0 by construction.
//    Exactly M tail symbols per frame, then back-to-back next frame allowed the following cycle.
//  - Backpressure: while out_valid && !out_ready, out_sym/out_last held stable; state, tail_cnt frozen.
//  - Output handshake and next load in the same cycle (out_ready=1) sustain 1 symbol/cycle.
//  - in_last without in_valid is ignored. in_bit/in_last sampled only on accept.
//  - tail_cnt width $clog2(M); never wraps past M-1.
//  - busy = (FSM==TAIL) || out_valid.
// TESTING
//  - Impulse, M=6 defaults, TAIL_EN=1, out_ready=1: frame {1}, in_last=1 -> 7 symbols
//    11,10,00,11,11,01,11 ({y1,y0}); out_last only on 7th; in_ready low for 6 cycles after accept.
//  - All-zero frame of 10 bits -> 16 symbols all 00, out_last on 16th; state 0 at end.
//  - Backpressure: random out_ready over a 64-bit random frame -> symbol stream identical to
//    out_ready=1 run; out_sym stable whenever out_valid && !out_ready; no symbol lost or duplicated.
//  - TAIL_EN=0, frames {1,0} then {1} -> 3 symbols 11,10,11; out_last on 2nd and 3rd (state reset).
//  - Reset mid-tail (after 3rd tail symbol) -> out_valid=0 next cycle, in_ready=1, next frame
//    {1} reproduces impulse response exactly.
//  - Loopback: encode 200 random bits + tail, feed to Viterbi decoder with force_state0
//    -> decoded bits equal input, zero errors.

Source files
------------

// File: rtl/conv_encoder.sv
// -----------------------------------------------------------------------------
// conv_encoder
//   Rate-1/2 feedforward convolutional encoder with valid/ready framing.
//   Each accepted information bit yields one 2-bit code symbol {y1, y0} one
//   cycle later. When TAIL_EN is set, M zero tail bits are appended after the
//   bit flagged by in_last, so every frame ends in encoder state 0. The state
//   convention is next_state = {state[M-2:0], in_bit}, matching the decoder.
//
// Ports
//   clk        in   1  clock, rising edge
//   rst        in   1  synchronous active-high reset
//   in_valid   in   1  in_bit valid
//   in_ready   out  1  encoder accepts in_bit this cycle
//   in_bit     in   1  information bit
//   in_last    in   1  in_bit is the final bit of the frame
//   out_valid  out  1  out_sym valid
//   out_ready  in   1  downstream accepts out_sym this cycle
//   out_sym    out  2  {y1, y0} code symbol
//   out_last   out  1  final symbol of the frame
//   busy       out  1  tail in progress or symbol pending
// -----------------------------------------------------------------------------
module conv_encoder #(
    parameter int           M       = 6,
    parameter logic [M:0]   G0      = 7'o171,
    parameter logic [M:0]   G1      = 7'o133,
    parameter bit           TAIL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_sym,
    output logic       out_last,
    output logic       busy
);

    localparam int            TW        = (M > 1) ? $clog2(M) : 1;
    localparam logic [TW-1:0] TAIL_LAST = TW'(M - 1);

    localparam logic [0:0] ST_DATA = 1'b0;
    localparam logic [0:0] ST_TAIL = 1'b1;

    // Parity of the tapped register bits; bit 0 of r is the current input,
    // bit M the oldest stored bit.
    function automatic logic [1:0] encode_sym(input logic [M-1:0] st, input logic b);
        logic [M:0] r;
        r = {st, b};
        return {^(r & G1), ^(r & G0)};
    endfunction

    logic [M-1:0]  state_q,     state_d;
    logic [0:0]    fsm_q,       fsm_d;
    logic [TW-1:0] tail_cnt_q,  tail_cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [1:0]    out_sym_q,   out_sym_d;
    logic          out_last_q,  out_last_d;
    logic          busy_q,      busy_d;
    logic          out_free_s;

    // Next-state logic: data acceptance, tail generation and output register load.
    always_comb begin
        state_d     = state_q;
        fsm_d       = fsm_q;
        tail_cnt_d  = tail_cnt_q;
        out_valid_d = out_valid_q;
        out_sym_d   = out_sym_q;
        out_last_d  = out_last_q;
        // The single output slot can be refilled when empty or being drained now.
        out_free_s  = !out_valid_q || out_ready;
        in_ready    = 1'b0;

        case (fsm_q)
            ST_DATA: begin
                in_ready = out_free_s;
                if (in_valid && out_free_s) begin
                    out_sym_d   = encode_sym(state_q, in_bit);
                    out_valid_d = 1'b1;
                    state_d     = {state_q[M-2:0], in_bit};
                    if (in_last) begin
                        if (TAIL_EN) begin
                            fsm_d      = ST_TAIL;
                            tail_cnt_d = {TW{1'b0}};
                            out_last_d = 1'b0;
                        end else begin
                            // Without a tail the next frame must still start from state 0.
                            out_last_d = 1'b1;
                            state_d    = {M{1'b0}};
                        end
                    end else begin
                        out_last_d = 1'b0;
                    end
                end else if (out_free_s) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            ST_TAIL: begin
                in_ready = 1'b0;
                if (out_free_s) begin
                    out_sym_d   = encode_sym(state_q, 1'b0);
                    out_valid_d = 1'b1;
                    state_d     = {state_q[M-2:0], 1'b0};
                    if (tail_cnt_q == TAIL_LAST) begin
                        // M zeros have been shifted in, so state_d is already 0.
                        out_last_d = 1'b1;
                        fsm_d      = ST_DATA;
                        tail_cnt_d = tail_cnt_q;
                    end else begin
                        out_last_d = 1'b0;
                        tail_cnt_d = tail_cnt_q + TW'(1);
                    end
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            default: begin
                fsm_d       = ST_DATA;
                state_d     = {M{1'b0}};
                tail_cnt_d  = {TW{1'b0}};
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase

        busy_d = (fsm_d == ST_TAIL) || out_valid_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= {M{1'b0}};
            fsm_q       <= ST_DATA;
            tail_cnt_q  <= {TW{1'b0}};
            out_valid_q <= 1'b0;
            out_sym_q   <= 2'b00;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fsm_q       <= fsm_d;
            tail_cnt_q  <= tail_cnt_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sym   = out_sym_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_conv_encoder.sv
// -----------------------------------------------------------------------------
// tb_conv_encoder
//   Directed bench for conv_encoder (M=6, G0=171, G1=133). A second instance
//   with TAIL_EN=0 covers the no-tail framing.
// -----------------------------------------------------------------------------
module tb_conv_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_bit, in_last;
    logic       out_valid, out_ready, out_last, busy;
    logic [1:0] out_sym;

    logic       v2, ir2, b2, l2, ov2, r2, ol2, by2;
    logic [1:0] os2;

    int errors = 0;
    int checks = 0;

    logic [1:0] rx_sym[$];
    bit         rx_last[$];
    int         rdy_low;

    logic [1:0] imp_exp  [7] = '{2'b11, 2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b11};
    logic [1:0] pair_exp [8] = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b10, 2'b11};

    always #5 clk = ~clk;

    conv_encoder #(.M(6), .G0(7'o171), .G1(7'o133), .TAIL_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
        .out_last(out_last), .busy(busy)
    );

    conv_encoder #(.M(6), .G0(7'o171), .G1(7'o133), .TAIL_EN(1'b0)) dut_nt (
        .clk(clk), .rst(rst),
        .in_valid(v2), .in_ready(ir2), .in_bit(b2), .in_last(l2),
        .out_valid(ov2), .out_ready(r2), .out_sym(os2),
        .out_last(ol2), .busy(by2)
    );

    // Feed bits[0..n-1] as one frame and collect symbols until out_last.
    task automatic send_frame(input logic [63:0] bits, input int n, input bit rnd);
        int   idx = 0;
        int   cyc = 0;
        bit   done = 1'b0;
        bit   stalled = 1'b0;
        logic [1:0] st_sym = 2'b00;
        rx_sym.delete();
        rx_last.delete();
        rdy_low = 0;
        while (!done && cyc < 2000) begin
            in_valid  = (idx < n);
            in_bit    = (idx < n) ? bits[idx] : 1'b0;
            in_last   = (idx == n - 1);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_sym !== st_sym) begin
                    errors++;
                    $display("FAIL stall_hold: out_valid=%b out_sym=%b, required 1 and %b",
                             out_valid, out_sym, st_sym);
                end
            end
            if (idx >= n && !in_ready) rdy_low++;
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                rx_sym.push_back(out_sym);
                rx_last.push_back(out_last);
                if (out_last) done = 1'b1;
            end
            stalled = out_valid && !out_ready;
            st_sym  = out_sym;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        if (!done) begin
            errors++;
            $display("FAIL frame_timeout: %0d symbols after %0d cycles, required out_last",
                     rx_sym.size(), cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        v2 = 1'b0; b2 = 1'b0; l2 = 1'b0; r2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({out_valid, out_sym, out_last, busy, in_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_state: {ov,sym,last,busy,in_ready}=%b, required 000001",
                     {out_valid, out_sym, out_last, busy, in_ready});
        end
    endtask

    task automatic test_impulse();
        send_frame(64'd1, 1, 1'b0);
        checks++;
        if (rx_sym.size() != 7) begin
            errors++;
            $display("FAIL impulse_len: %0d symbols, required 7", rx_sym.size());
        end
        for (int i = 0; i < 7 && i < rx_sym.size(); i++) begin
            checks++;
            if (rx_sym[i] !== imp_exp[i] || rx_last[i] !== (i == 6)) begin
                errors++;
                $display("FAIL impulse_sym[%0d]: sym=%b last=%b, required %b last=%b",
                         i, rx_sym[i], rx_last[i], imp_exp[i], (i == 6));
            end
        end
        checks++;
        if (rdy_low != 6) begin
            errors++;
            $display("FAIL impulse_ready_low: %0d cycles, required 6", rdy_low);
        end
    endtask

    task automatic test_zero_frame();
        send_frame(64'd0, 10, 1'b0);
        checks++;
        if (rx_sym.size() != 16) begin
            errors++;
            $display("FAIL zero_len: %0d symbols, required 16", rx_sym.size());
        end
        for (int i = 0; i < rx_sym.size(); i++) begin
            checks++;
            if (rx_sym[i] !== 2'b00 || rx_last[i] !== (i == 15)) begin
                errors++;
                $display("FAIL zero_sym[%0d]: sym=%b last=%b, required 00 last=%b",
                         i, rx_sym[i], rx_last[i], (i == 15));
            end
        end
        // A following impulse only matches if the frame left state 0.
        send_frame(64'd1, 1, 1'b0);
        checks++;
        if (rx_sym.size() < 2 || rx_sym[0] !== 2'b11 || rx_sym[1] !== 2'b10) begin
            errors++;
            $display("FAIL zero_end_state: first symbols %b %b, required 11 10",
                     (rx_sym.size() > 0) ? rx_sym[0] : 2'bxx,
                     (rx_sym.size() > 1) ? rx_sym[1] : 2'bxx);
        end
    endtask

    task automatic test_pair();
        send_frame(64'd3, 2, 1'b0);
        checks++;
        if (rx_sym.size() != 8) begin
            errors++;
            $display("FAIL pair_len: %0d symbols, required 8", rx_sym.size());
        end
        for (int i = 0; i < 8 && i < rx_sym.size(); i++) begin
            checks++;
            if (rx_sym[i] !== pair_exp[i] || rx_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL pair_sym[%0d]: sym=%b last=%b, required %b last=%b",
                         i, rx_sym[i], rx_last[i], pair_exp[i], (i == 7));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] bits;
        logic [1:0]  ref_sym[$];
        bits = {32'($urandom), 32'($urandom)};
        send_frame(bits, 64, 1'b0);
        ref_sym = rx_sym;
        checks++;
        if (ref_sym.size() != 70) begin
            errors++;
            $display("FAIL bp_ref_len: %0d symbols, required 70", ref_sym.size());
        end
        send_frame(bits, 64, 1'b1);
        checks++;
        if (rx_sym.size() != 70) begin
            errors++;
            $display("FAIL bp_len: %0d symbols, required 70", rx_sym.size());
        end
        for (int i = 0; i < rx_sym.size() && i < ref_sym.size(); i++) begin
            checks++;
            if (rx_sym[i] !== ref_sym[i] || rx_last[i] !== (i == 69)) begin
                errors++;
                $display("FAIL bp_sym[%0d]: sym=%b last=%b, required %b last=%b",
                         i, rx_sym[i], rx_last[i], ref_sym[i], (i == 69));
            end
        end
    endtask

    task automatic test_no_tail();
        logic [2:0] bseq = 3'b101;   // bit i is the i-th bit sent
        logic [2:0] lseq = 3'b110;
        logic [1:0] exp_s [3] = '{2'b11, 2'b10, 2'b11};
        logic [1:0] got_s [3];
        bit         got_l [3];
        int idx = 0;
        int cnt = 0;
        int cyc = 0;
        while (cnt < 3 && cyc < 50) begin
            v2 = (idx < 3);
            b2 = (idx < 3) ? bseq[idx] : 1'b0;
            l2 = (idx < 3) ? lseq[idx] : 1'b0;
            r2 = 1'b1;
            #1;
            if (v2 && ir2) idx++;
            if (ov2 && r2) begin
                got_s[cnt] = os2;
                got_l[cnt] = ol2;
                cnt++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        v2 = 1'b0;
        l2 = 1'b0;
        checks++;
        if (cnt != 3) begin
            errors++;
            $display("FAIL notail_count: %0d symbols, required 3", cnt);
        end
        for (int i = 0; i < cnt; i++) begin
            checks++;
            if (got_s[i] !== exp_s[i] || got_l[i] !== (i != 0)) begin
                errors++;
                $display("FAIL notail_sym[%0d]: sym=%b last=%b, required %b last=%b",
                         i, got_s[i], got_l[i], exp_s[i], (i != 0));
            end
        end
    endtask

    task automatic test_reset_mid_tail();
        int cnt = 0;
        int cyc = 0;
        bit acc = 1'b0;
        in_bit = 1'b1; in_last = 1'b1; out_ready = 1'b1;
        while (cnt < 4 && cyc < 50) begin
            in_valid = !acc;
            #1;
            if (in_valid && in_ready) acc = 1'b1;
            if (out_valid && out_ready) cnt++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (cnt != 4) begin
            errors++;
            $display("FAIL midtail_reach: %0d symbols, required 4", cnt);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL midtail_reset: {ov,busy,in_ready}=%b, required 001",
                     {out_valid, busy, in_ready});
        end
        send_frame(64'd1, 1, 1'b0);
        checks++;
        if (rx_sym.size() != 7) begin
            errors++;
            $display("FAIL midtail_len: %0d symbols, required 7", rx_sym.size());
        end
        for (int i = 0; i < 7 && i < rx_sym.size(); i++) begin
            checks++;
            if (rx_sym[i] !== imp_exp[i] || rx_last[i] !== (i == 6)) begin
                errors++;
                $display("FAIL midtail_sym[%0d]: sym=%b last=%b, required %b last=%b",
                         i, rx_sym[i], rx_last[i], imp_exp[i], (i == 6));
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_zero_frame();
        test_pair();
        test_backpressure();
        test_no_tail();
        test_reset_mid_tail();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
